// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its bus.
package fetch_pkg;

    // First fetch address after reset.
    localparam logic [63:0] PCINIT  = 64'h8000_0000;
    localparam logic [63:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
        logic        is_bubble;
    } fetch_data_t;

    // Sequential successor; 64-bit add wraps naturally, no alignment check.
    function automatic logic [63:0] next_pc(input logic [63:0] pc);
        return pc + PC_STEP;
    endfunction

    function automatic ibus_req_t req_at(input logic [63:0] addr);
        return '{valid: 1'b1, addr: addr};
    endfunction

endpackage

// File: rtl/fetch.sv
// Instruction fetch: one outstanding bus request, one-entry skid buffer for
// decode back-pressure, redirect handling with in-flight response discard.
module fetch
    import fetch_pkg::ibus_req_t, fetch_pkg::ibus_resp_t, fetch_pkg::fetch_data_t,
           fetch_pkg::next_pc, fetch_pkg::req_at;
#(
    parameter logic [63:0] PCINIT = fetch_pkg::PCINIT
) (
    input  logic        clk,
    input  logic        reset,
    output ibus_req_t   ireq,
    input  ibus_resp_t  iresp,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output fetch_data_t dataF
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD,
        DISCARD
    } state_t;

    state_t      state;
    logic [63:0] pc;
    logic [63:0] target;
    logic [31:0] skid_instr;
    logic [63:0] skid_pc;

    // addr_ok carries no information here: the request is simply held until data_ok.
    logic unused_addr_ok;
    assign unused_addr_ok = iresp.addr_ok;

    // Fetch FSM with registered bus request, pc, skid entry and decode register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= PCINIT;
            target     <= '0;
            skid_instr <= '0;
            skid_pc    <= '0;
            ireq       <= '{valid: 1'b0, addr: 64'd0};
            dataF      <= '{raw_instr: 32'd0, pc: 64'd0, is_bubble: 1'b1};
        end else begin
            // A redirect always kills the decode slot; otherwise any cycle decode
            // can accept gets a bubble unless a delivery below overrides it.
            if (redirect_valid || !stall)
                dataF.is_bubble <= 1'b1;

            case (state)
                IDLE: begin
                    state <= REQ;
                    if (redirect_valid) begin
                        pc   <= redirect_pc;
                        ireq <= req_at(redirect_pc);
                    end else begin
                        ireq <= req_at(pc);
                    end
                end

                REQ: begin
                    if (redirect_valid) begin
                        if (iresp.data_ok) begin
                            // Response lands with the redirect: drop it, restart at once.
                            pc   <= redirect_pc;
                            ireq <= req_at(redirect_pc);
                        end else begin
                            // Bus request must stay stable until its data returns.
                            target <= redirect_pc;
                            state  <= DISCARD;
                        end
                    end else if (iresp.data_ok) begin
                        if (stall) begin
                            skid_instr <= iresp.data;
                            skid_pc    <= pc;
                            ireq.valid <= 1'b0;
                            state      <= HOLD;
                        end else begin
                            dataF <= '{raw_instr: iresp.data, pc: pc, is_bubble: 1'b0};
                            pc    <= next_pc(pc);
                            ireq  <= req_at(next_pc(pc));
                        end
                    end
                end

                HOLD: begin
                    if (redirect_valid) begin
                        skid_instr <= '0;
                        skid_pc    <= '0;
                        pc         <= redirect_pc;
                        ireq       <= req_at(redirect_pc);
                        state      <= REQ;
                    end else if (!stall) begin
                        dataF      <= '{raw_instr: skid_instr, pc: skid_pc, is_bubble: 1'b0};
                        pc         <= next_pc(skid_pc);
                        ireq       <= req_at(next_pc(skid_pc));
                        skid_instr <= '0;
                        skid_pc    <= '0;
                        state      <= REQ;
                    end
                end

                DISCARD: begin
                    // Newest redirect wins, including one arriving with the dropped data.
                    if (redirect_valid)
                        target <= redirect_pc;
                    if (iresp.data_ok) begin
                        pc    <= redirect_valid ? redirect_pc : target;
                        ireq  <= req_at(redirect_valid ? redirect_pc : target);
                        state <= REQ;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios followed by a randomized
// phase scored against rule-level expectations on the delivered stream.
module tb_fetch;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    ibus_req_t   ireq;
    ibus_resp_t  iresp;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    fetch_data_t dataF;

    int total = 0;
    int bad   = 0;

    fetch dut (
        .clk           (clk),
        .reset         (reset),
        .ireq          (ireq),
        .iresp         (iresp),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dataF         (dataF)
    );

    always #5 clk = ~clk;

    // Memory contents: a fixed word at 8000_0008, a hash of the address elsewhere.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h8000_0008) return 32'h0050_0093;
        return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
    endfunction

    function automatic ibus_req_t rq(input logic v, input logic [63:0] a);
        ibus_req_t r;
        r.valid = v;
        r.addr  = a;
        return r;
    endfunction

    function automatic fetch_data_t fd(input logic [31:0] i, input logic [63:0] p, input logic b);
        fetch_data_t d;
        d.raw_instr = i;
        d.pc        = p;
        d.is_bubble = b;
        return d;
    endfunction

    task automatic chk_req(input string tag, input ibus_req_t got, input ibus_req_t exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h/%0h exp=%0h/%0h", tag, got.valid, got.addr, exp.valid, exp.addr);
        end
    endtask

    task automatic chk_fd(input string tag, input fetch_data_t got, input fetch_data_t exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h/%0h/%0h exp=%0h/%0h/%0h", tag, got.raw_instr, got.pc,
                   got.is_bubble, exp.raw_instr, exp.pc, exp.is_bubble);
        end
    endtask

    task automatic chk64(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled on the next falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic ok, input logic st, input logic rv, input logic [63:0] rpc);
        iresp.addr_ok  = ok;
        iresp.data_ok  = ok;
        iresp.data     = ok ? mem_word(ireq.addr) : 32'hdead_0000;
        stall          = st;
        redirect_valid = rv;
        redirect_pc    = rpc;
    endtask

    initial begin
        logic        ok, st, rv;
        logic [63:0] a, rpc, exp_next;
        int          mem_wait, deliveries;
        ibus_req_t   p_ireq;
        fetch_data_t p_dataF, prev;

        reset = 1'b1;
        iresp = '0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        tick();
        chk_req("rst_ireq", ireq, rq(1'b0, 64'd0));
        chk_fd("rst_dataF", dataF, fd(32'd0, 64'd0, 1'b1));

        // Reset release, memory answering every second cycle.
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        chk_req("first_req", ireq, rq(1'b1, 64'h8000_0000));
        for (int i = 0; i < 2; i++) begin
            a = 64'h8000_0000 + 64'(4 * i);
            drive(1'b0, 1'b0, 1'b0, 64'd0);
            tick();
            chk_req("seq_wait_addr", ireq, rq(1'b1, a));
            chk64("seq_bubble", 64'(dataF.is_bubble), 64'd1);
            drive(1'b1, 1'b0, 1'b0, 64'd0);
            tick();
            chk_fd("seq_data", dataF, fd(mem_word(a), a, 1'b0));
            chk_req("seq_next_addr", ireq, rq(1'b1, a + 64'd4));
        end

        // Stall on data return: skid, hold three cycles, then release.
        prev = dataF;
        drive(1'b1, 1'b1, 1'b0, 64'd0);
        tick();
        chk64("hold_valid", 64'(ireq.valid), 64'd0);
        chk_fd("hold_dataF", dataF, prev);
        repeat (2) begin
            drive(1'b0, 1'b1, 1'b0, 64'd0);
            tick();
            chk64("hold_valid2", 64'(ireq.valid), 64'd0);
            chk_fd("hold_dataF2", dataF, prev);
        end
        drive(1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        chk_fd("hold_release", dataF, fd(32'h0050_0093, 64'h8000_0008, 1'b0));
        chk_req("hold_next", ireq, rq(1'b1, 64'h8000_000C));
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        chk_fd("deliver_c", dataF, fd(mem_word(64'h8000_000C), 64'h8000_000C, 1'b0));

        // Redirect while a request is outstanding: old address held, data dropped.
        drive(1'b0, 1'b0, 1'b1, 64'h8000_0100);
        tick();
        chk_req("disc_hold1", ireq, rq(1'b1, 64'h8000_0010));
        chk64("disc_bubble", 64'(dataF.is_bubble), 64'd1);
        drive(1'b0, 1'b0, 1'b0, 64'd0);
        tick();
        chk_req("disc_hold2", ireq, rq(1'b1, 64'h8000_0010));
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        chk64("disc_dropped", 64'(dataF.is_bubble), 64'd1);
        chk_req("disc_resume", ireq, rq(1'b1, 64'h8000_0100));

        // Redirect coinciding with data_ok.
        drive(1'b1, 1'b0, 1'b1, 64'h8000_0200);
        tick();
        chk64("same_bubble", 64'(dataF.is_bubble), 64'd1);
        chk_req("same_next", ireq, rq(1'b1, 64'h8000_0200));
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        chk_fd("same_deliver", dataF, fd(mem_word(64'h8000_0200), 64'h8000_0200, 1'b0));

        // Two redirects while discarding; the first also arrives under stall.
        drive(1'b0, 1'b1, 1'b1, 64'h8000_0300);
        tick();
        chk64("two_bub_stall", 64'(dataF.is_bubble), 64'd1);
        chk_req("two_hold1", ireq, rq(1'b1, 64'h8000_0204));
        drive(1'b0, 1'b0, 1'b1, 64'h8000_0400);
        tick();
        chk_req("two_hold2", ireq, rq(1'b1, 64'h8000_0204));
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        chk_req("two_resume", ireq, rq(1'b1, 64'h8000_0400));
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        chk_fd("two_deliver", dataF, fd(mem_word(64'h8000_0400), 64'h8000_0400, 1'b0));

        // PC wraps modulo 2^64.
        drive(1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        tick();
        chk_req("wrap_req", ireq, rq(1'b1, 64'hFFFF_FFFF_FFFF_FFFC));
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        chk_fd("wrap_data", dataF, fd(mem_word(64'hFFFF_FFFF_FFFF_FFFC), 64'hFFFF_FFFF_FFFF_FFFC, 1'b0));
        chk_req("wrap_next", ireq, rq(1'b1, 64'd0));

        // Reset while holding a skid entry; stale data_ok through and after reset.
        drive(1'b1, 1'b1, 1'b0, 64'd0);
        tick();
        chk64("rst_hold_valid", 64'(ireq.valid), 64'd0);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 64'd0);
        tick();
        chk_req("rst2_ireq", ireq, rq(1'b0, 64'd0));
        chk_fd("rst2_dataF", dataF, fd(32'd0, 64'd0, 1'b1));
        reset = 1'b0;
        tick();
        chk_req("rst2_first", ireq, rq(1'b1, 64'h8000_0000));
        chk_fd("rst2_stale", dataF, fd(32'd0, 64'd0, 1'b1));

        // Randomized phase: the delivered stream must follow pc+4 from the
        // latest redirect target, stalls freeze dataF, requests stay stable.
        exp_next   = PCINIT;
        deliveries = 0;
        mem_wait   = int'($urandom_range(0, 2));
        for (int c = 0; c < 3000; c++) begin
            st  = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 11) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
            ok  = 1'b0;
            if (ireq.valid) begin
                if (mem_wait == 0) begin
                    ok = 1'b1;
                    mem_wait = int'($urandom_range(0, 2));
                end else begin
                    mem_wait--;
                end
            end
            drive(ok, st, rv, rpc);
            p_ireq  = ireq;
            p_dataF = dataF;
            tick();
            if (rv) begin
                chk64("rnd_redir_bubble", 64'(dataF.is_bubble), 64'd1);
                exp_next = rpc;
            end else if (st) begin
                chk_fd("rnd_stall_hold", dataF, p_dataF);
            end else if (!dataF.is_bubble) begin
                chk64("rnd_pc", dataF.pc, exp_next);
                chk64("rnd_instr", 64'(dataF.raw_instr), 64'(mem_word(exp_next)));
                exp_next = exp_next + 64'd4;
                deliveries++;
            end
            if (p_ireq.valid && !ok)
                chk_req("rnd_addr_hold", ireq, p_ireq);
        end
        chk64("rnd_progress", 64'(deliveries > 200), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
